id_ex_reg: RTL and testbench



---
 rtl/id_ex_reg.sv | 156 +++++++++++++++
 tb/tb_id_ex_reg.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register of the 5-stage MIPS core, with load-use hazard
// detection, EX hold, branch flush and illegal-extension-mode trapping.
module id_ex_reg #(
    parameter int CTRL_W       = 16,
    parameter int MEMREAD_BIT  = 3,
    parameter int REGWRITE_BIT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [31:0]       id_pc,
    input  logic [31:0]       id_instr,
    input  logic [31:0]       id_rs_data,
    input  logic [31:0]       id_rt_data,
    input  logic [31:0]       id_ext_imm,
    input  logic [1:0]        id_ext_sel,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [4:0]        id_wr_reg,
    output logic              ex_valid,
    output logic [31:0]       ex_pc,
    output logic [31:0]       ex_instr,
    output logic [31:0]       ex_rs_data,
    output logic [31:0]       ex_rt_data,
    output logic [31:0]       ex_ext_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [4:0]        ex_wr_reg,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic              load_use_stall,
    output logic              ext_err
);

    logic              ex_valid_q,   ex_valid_d;
    logic [31:0]       ex_pc_q,      ex_pc_d;
    logic [31:0]       ex_instr_q,   ex_instr_d;
    logic [31:0]       ex_rs_data_q, ex_rs_data_d;
    logic [31:0]       ex_rt_data_q, ex_rt_data_d;
    logic [31:0]       ex_ext_imm_q, ex_ext_imm_d;
    logic [CTRL_W-1:0] ex_ctrl_q,    ex_ctrl_d;
    logic [4:0]        ex_wr_reg_q,  ex_wr_reg_d;
    logic [4:0]        ex_rs_q,      ex_rs_d;
    logic [4:0]        ex_rt_q,      ex_rt_d;
    logic              ext_err_q,    ext_err_d;

    logic              hazard_s;
    logic              stall_s;
    logic              ext_ill_s;
    logic [CTRL_W-1:0] ctrl_cap_s;
    logic [CTRL_W-1:0] regwrite_mask_s;

    // A load in EX whose destination is read by the instruction in ID.
    assign hazard_s = ex_valid_q & ex_ctrl_q[MEMREAD_BIT] & id_valid &
                      (ex_wr_reg_q != 5'd0) &
                      ((ex_wr_reg_q == id_instr[25:21]) |
                       (ex_wr_reg_q == id_instr[20:16]));
    assign stall_s  = hazard_s & ~reset & ~flush;

    assign ext_ill_s       = id_valid & (id_ext_sel == 2'b11);
    assign regwrite_mask_s = ~({{(CTRL_W-1){1'b0}}, ext_ill_s} << REGWRITE_BIT);

    // Control captured from ID: invalid slots carry no control, illegal modes lose the write.
    always_comb begin
        ctrl_cap_s = {CTRL_W{1'b0}};
        if (id_valid) begin
            ctrl_cap_s = id_ctrl & regwrite_mask_s;
        end else begin
            ctrl_cap_s = {CTRL_W{1'b0}};
        end
    end

    // Next-state selection: flush, then hold, then load-use bubble, then capture.
    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_pc_d      = ex_pc_q;
        ex_instr_d   = ex_instr_q;
        ex_rs_data_d = ex_rs_data_q;
        ex_rt_data_d = ex_rt_data_q;
        ex_ext_imm_d = ex_ext_imm_q;
        ex_ctrl_d    = ex_ctrl_q;
        ex_wr_reg_d  = ex_wr_reg_q;
        ex_rs_d      = ex_rs_q;
        ex_rt_d      = ex_rt_q;
        ext_err_d    = 1'b0;
        if (flush || (!hold && stall_s)) begin
            ex_valid_d   = 1'b0;
            ex_pc_d      = 32'd0;
            ex_instr_d   = 32'd0;
            ex_rs_data_d = 32'd0;
            ex_rt_data_d = 32'd0;
            ex_ext_imm_d = 32'd0;
            ex_ctrl_d    = {CTRL_W{1'b0}};
            ex_wr_reg_d  = 5'd0;
            ex_rs_d      = 5'd0;
            ex_rt_d      = 5'd0;
        end else if (hold) begin
            ext_err_d    = 1'b0;
        end else begin
            ex_valid_d   = id_valid;
            ex_pc_d      = id_pc;
            ex_instr_d   = id_instr;
            ex_rs_data_d = id_rs_data;
            ex_rt_data_d = id_rt_data;
            ex_ext_imm_d = ext_ill_s ? 32'd0 : id_ext_imm;
            ex_ctrl_d    = ctrl_cap_s;
            ex_wr_reg_d  = id_valid ? id_wr_reg : 5'd0;
            ex_rs_d      = id_instr[25:21];
            ex_rt_d      = id_instr[20:16];
            ext_err_d    = ext_ill_s;
        end
    end

    // State registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q   <= 1'b0;
            ex_pc_q      <= 32'd0;
            ex_instr_q   <= 32'd0;
            ex_rs_data_q <= 32'd0;
            ex_rt_data_q <= 32'd0;
            ex_ext_imm_q <= 32'd0;
            ex_ctrl_q    <= {CTRL_W{1'b0}};
            ex_wr_reg_q  <= 5'd0;
            ex_rs_q      <= 5'd0;
            ex_rt_q      <= 5'd0;
            ext_err_q    <= 1'b0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_pc_q      <= ex_pc_d;
            ex_instr_q   <= ex_instr_d;
            ex_rs_data_q <= ex_rs_data_d;
            ex_rt_data_q <= ex_rt_data_d;
            ex_ext_imm_q <= ex_ext_imm_d;
            ex_ctrl_q    <= ex_ctrl_d;
            ex_wr_reg_q  <= ex_wr_reg_d;
            ex_rs_q      <= ex_rs_d;
            ex_rt_q      <= ex_rt_d;
            ext_err_q    <= ext_err_d;
        end
    end

    assign ex_valid       = ex_valid_q;
    assign ex_pc          = ex_pc_q;
    assign ex_instr       = ex_instr_q;
    assign ex_rs_data     = ex_rs_data_q;
    assign ex_rt_data     = ex_rt_data_q;
    assign ex_ext_imm     = ex_ext_imm_q;
    assign ex_ctrl        = ex_ctrl_q;
    assign ex_wr_reg      = ex_wr_reg_q;
    assign ex_rs          = ex_rs_q;
    assign ex_rt          = ex_rt_q;
    assign ext_err        = ext_err_q;
    assign load_use_stall = stall_s;

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: directed scenarios plus a randomized run
// against a behavioural model of the EX-side state.
module tb_id_ex_reg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [31:0] imm;
        logic [15:0] ctrl;
        logic [4:0]  wr;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        err;
    } ex_t;

    logic        clk = 1'b0;
    logic        reset, hold, flush, id_valid;
    logic [31:0] id_pc, id_instr, id_rs_data, id_rt_data, id_ext_imm;
    logic [1:0]  id_ext_sel;
    logic [15:0] id_ctrl;
    logic [4:0]  id_wr_reg;
    logic        ex_valid, load_use_stall, ext_err;
    logic [31:0] ex_pc, ex_instr, ex_rs_data, ex_rt_data, ex_ext_imm;
    logic [15:0] ex_ctrl;
    logic [4:0]  ex_wr_reg, ex_rs, ex_rt;

    ex_t model, obs, held;
    int  n_cmp  = 0;
    int  n_fail = 0;

    localparam logic [31:0] LW9  = {6'h23, 5'd2, 5'd9, 16'h0004};
    localparam logic [31:0] ADD9 = {6'h00, 5'd9, 5'd3, 5'd10, 11'h020};
    localparam logic [31:0] LW0  = {6'h23, 5'd2, 5'd0, 16'h0004};
    localparam logic [31:0] ADD0 = {6'h00, 5'd0, 5'd3, 5'd10, 11'h020};

    always #5 clk = ~clk;

    id_ex_reg dut (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush),
        .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_ext_imm(id_ext_imm), .id_ext_sel(id_ext_sel),
        .id_ctrl(id_ctrl), .id_wr_reg(id_wr_reg),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_instr(ex_instr),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_ext_imm(ex_ext_imm), .ex_ctrl(ex_ctrl), .ex_wr_reg(ex_wr_reg),
        .ex_rs(ex_rs), .ex_rt(ex_rt),
        .load_use_stall(load_use_stall), .ext_err(ext_err)
    );

    always_comb obs = {ex_valid, ex_pc, ex_instr, ex_rs_data, ex_rt_data,
                       ex_ext_imm, ex_ctrl, ex_wr_reg, ex_rs, ex_rt, ext_err};

    // Does the instruction in ID read the register a load in EX is about to produce?
    function automatic logic exp_stall();
        logic reads;
        reads = (model.wr == id_instr[25:21]) || (model.wr == id_instr[20:16]);
        return !reset && !flush && model.valid && model.ctrl[3] && id_valid &&
               model.wr != 5'd0 && reads;
    endfunction

    function automatic ex_t model_next();
        ex_t n;
        n = '0;
        if (reset || flush || (!hold && exp_stall())) return n;
        if (hold) begin
            n = model;
            n.err = 1'b0;
            return n;
        end
        n.valid = id_valid;
        n.pc    = id_pc;
        n.instr = id_instr;
        n.rsd   = id_rs_data;
        n.rtd   = id_rt_data;
        n.rs    = id_instr[25:21];
        n.rt    = id_instr[20:16];
        n.imm   = id_ext_imm;
        if (id_valid) begin
            n.ctrl = id_ctrl;
            n.wr   = id_wr_reg;
            if (id_ext_sel == 2'b11) begin
                n.imm     = 32'd0;
                n.ctrl[0] = 1'b0;
                n.err     = 1'b1;
            end
        end
        return n;
    endfunction

    task automatic tick();
        ex_t nxt;
        nxt = model_next();
        @(posedge clk);
        #1;
        model = nxt;
    endtask

    task automatic set_id(input logic v, input logic [31:0] instr, input logic [15:0] ctrl,
                          input logic [4:0] wr, input logic [1:0] sel);
        id_valid   = v;
        id_instr   = instr;
        id_ctrl    = ctrl;
        id_wr_reg  = wr;
        id_ext_sel = sel;
        id_pc      = $urandom;
        id_rs_data = $urandom;
        id_rt_data = $urandom;
        id_ext_imm = $urandom;
    endtask

    task automatic test_reset();
        reset = 1'b1; hold = 1'b0; flush = 1'b0;
        set_id(1'b1, $urandom, 16'hFFFF, 5'd7, 2'b11);
        tick();
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (obs !== 193'd0 || load_use_stall !== 1'b0) begin
                n_fail++;
                $display("FAIL reset cyc%0d: got %h stall=%b, want 0 stall=0", i, obs, load_use_stall);
            end
            set_id(1'b1, $urandom, 16'hFFFF, 5'd7, 2'b11);
            tick();
        end
        reset = 1'b0;
    endtask

    task automatic test_normal();
        set_id(1'b1, 32'h2508_0004, 16'h0001, 5'd8, 2'b01);
        id_pc = 32'h0040_0010; id_ext_imm = 32'hFFFF_8000;
        tick();
        n_cmp++;
        if (ex_pc !== 32'h0040_0010 || ex_ext_imm !== 32'hFFFF_8000 ||
            ex_wr_reg !== 5'd8 || ex_valid !== 1'b1 || ex_rs !== 5'd8 || ex_rt !== 5'd8) begin
            n_fail++;
            $display("FAIL normal: got pc=%h imm=%h wr=%0d v=%b rs=%0d rt=%0d, want 00400010 ffff8000 8 1 8 8",
                     ex_pc, ex_ext_imm, ex_wr_reg, ex_valid, ex_rs, ex_rt);
        end
        n_cmp++;
        if (obs !== model) begin
            n_fail++;
            $display("FAIL normal_full: got %h want %h", obs, model);
        end
    endtask

    task automatic test_load_use();
        set_id(1'b1, LW9, 16'h0009, 5'd9, 2'b01);
        tick();
        set_id(1'b1, ADD9, 16'h0001, 5'd10, 2'b00);
        #1;
        n_cmp++;
        if (load_use_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL lu_stall: got %b want 1", load_use_stall);
        end
        tick();
        n_cmp++;
        if (ex_valid !== 1'b0 || ex_ctrl !== 16'h0000 || load_use_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL lu_bubble: got v=%b ctrl=%h stall=%b want 0 0000 0", ex_valid, ex_ctrl, load_use_stall);
        end
        tick();
        n_cmp++;
        if (ex_valid !== 1'b1 || ex_instr !== ADD9 || ex_wr_reg !== 5'd10 || obs !== model) begin
            n_fail++;
            $display("FAIL lu_capture: got v=%b instr=%h wr=%0d want 1 %h 10", ex_valid, ex_instr, ex_wr_reg, ADD9);
        end
        set_id(1'b1, LW0, 16'h0009, 5'd0, 2'b01);
        tick();
        set_id(1'b1, ADD0, 16'h0001, 5'd10, 2'b00);
        #1;
        n_cmp++;
        if (load_use_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL lu_r0_stall: got %b want 0", load_use_stall);
        end
        tick();
        n_cmp++;
        if (ex_valid !== 1'b1 || ex_instr !== ADD0) begin
            n_fail++;
            $display("FAIL lu_r0_capture: got v=%b instr=%h want 1 %h", ex_valid, ex_instr, ADD0);
        end
    endtask

    task automatic test_hold();
        set_id(1'b1, LW9, 16'h0009, 5'd9, 2'b01);
        tick();
        held = model;
        set_id(1'b1, ADD9, 16'h0001, 5'd10, 2'b00);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (load_use_stall !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_stall cyc%0d: got %b want 1", i, load_use_stall);
            end
            tick();
            n_cmp++;
            if (obs !== held) begin
                n_fail++;
                $display("FAIL hold_frozen cyc%0d: got %h want %h", i, obs, held);
            end
        end
        hold = 1'b0;
        tick();
        n_cmp++;
        if (ex_valid !== 1'b0 || ex_ctrl !== 16'h0000 || load_use_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_release_bubble: got v=%b ctrl=%h stall=%b want 0 0000 0", ex_valid, ex_ctrl, load_use_stall);
        end
        tick();
        n_cmp++;
        if (ex_valid !== 1'b1 || ex_instr !== ADD9) begin
            n_fail++;
            $display("FAIL hold_release_capture: got v=%b instr=%h want 1 %h", ex_valid, ex_instr, ADD9);
        end
    endtask

    task automatic test_flush();
        set_id(1'b1, LW9, 16'h0009, 5'd9, 2'b01);
        tick();
        set_id(1'b1, ADD9, 16'h0001, 5'd10, 2'b00);
        flush = 1'b1;
        #1;
        n_cmp++;
        if (load_use_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_stall: got %b want 0", load_use_stall);
        end
        tick();
        n_cmp++;
        if (obs !== 193'd0) begin
            n_fail++;
            $display("FAIL flush_bubble: got %h want 0", obs);
        end
        flush = 1'b0;
        set_id(1'b1, ADD9, 16'h0001, 5'd10, 2'b00);
        tick();
        flush = 1'b1; hold = 1'b1;
        tick();
        n_cmp++;
        if (obs !== 193'd0) begin
            n_fail++;
            $display("FAIL flush_over_hold: got %h want 0", obs);
        end
        flush = 1'b0; hold = 1'b0;
    endtask

    task automatic test_illegal();
        set_id(1'b1, 32'h3C01_1234, 16'h0001, 5'd1, 2'b11);
        id_ext_imm = 32'hDEAD_BEEF;
        tick();
        n_cmp++;
        if (ex_ext_imm !== 32'd0 || ex_ctrl[0] !== 1'b0 || ext_err !== 1'b1 || ex_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_capture: got imm=%h ctrl0=%b err=%b v=%b want 0 0 1 1", ex_ext_imm, ex_ctrl[0], ext_err, ex_valid);
        end
        set_id(1'b1, 32'h3C01_1234, 16'h0001, 5'd1, 2'b10);
        tick();
        n_cmp++;
        if (ext_err !== 1'b0 || ex_ctrl[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_pulse: got err=%b ctrl0=%b want 0 1", ext_err, ex_ctrl[0]);
        end
        set_id(1'b0, 32'h3C01_1234, 16'h0001, 5'd1, 2'b11);
        tick();
        n_cmp++;
        if (ext_err !== 1'b0 || ex_valid !== 1'b0 || ex_ctrl !== 16'h0000 || ex_wr_reg !== 5'd0) begin
            n_fail++;
            $display("FAIL illegal_invalid: got err=%b v=%b ctrl=%h wr=%0d want 0 0 0000 0", ext_err, ex_valid, ex_ctrl, ex_wr_reg);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(39) == 0);
            flush = ($urandom_range(9) == 0);
            hold  = ($urandom_range(5) == 0);
            set_id(($urandom_range(3) != 0),
                   {6'($urandom), 5'($urandom_range(3)), 5'($urandom_range(3)), 16'($urandom)},
                   16'($urandom), 5'($urandom_range(3)), 2'($urandom));
            #1;
            n_cmp++;
            if (load_use_stall !== exp_stall()) begin
                n_fail++;
                $display("FAIL rand_stall cyc%0d: got %b want %b", i, load_use_stall, exp_stall());
            end
            tick();
            n_cmp++;
            if (obs !== model) begin
                n_fail++;
                $display("FAIL rand_state cyc%0d: got %h want %h", i, obs, model);
            end
        end
        reset = 1'b0; flush = 1'b0; hold = 1'b0;
    endtask

    initial begin
        model = '0;
        reset = 1'b1; hold = 1'b0; flush = 1'b0;
        set_id(1'b0, 32'd0, 16'd0, 5'd0, 2'b00);
        #1;
        test_reset();
        test_normal();
        test_load_use();
        test_hold();
        test_flush();
        test_illegal();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
